// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI bus scheduler: FSM state type, default
// frame width and the fixed SPI mode (CPOL=1, CPHA=1).
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int FRAME_BITS_DEF = 16;

  // SPI mode: clock idles high, data launched on falling and captured on rising.
  localparam logic CPOL = 1'b1;
  localparam logic CPHA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

endpackage

// File: rtl/spi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// spi_rr_arbiter
// Combinational round-robin arbiter. The requester at index 'ptr' has the
// highest priority, then ptr+1, ... wrapping around.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index holding highest priority this round
//   grant - one-hot winner, all zero when no request
// ---------------------------------------------------------------------------
module spi_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant
);

  // Walk from lowest to highest priority so the last match written wins.
  always_comb begin
    int idx;
    grant = '0;
    idx   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) grant = NREQ'(1) << idx;
    end
  end

endmodule

// File: rtl/spi_bus_scheduler.sv
// ---------------------------------------------------------------------------
// spi_bus_scheduler
// Shares one SPI master (CPOL=1, CPHA=1, MSB first) between NREQ requesters.
// A requester holds req high; when the bus is idle a round-robin winner is
// granted, its tx word is shifted out while miso is shifted in, and the
// owner gets a one-cycle done pulse with rx_data valid from then on.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   req          - per-requester level request
//   tx_data      - per-requester transmit word, slice i for requester i
//   grant        - one-hot owner of the current frame
//   done         - one-cycle pulse to the owner at frame end
//   rx_data      - last received word
//   busy         - high whenever the FSM is not idle
//   cs/dclk/mosi - SPI outputs (registered); miso - SPI serial input
// ---------------------------------------------------------------------------
module spi_bus_scheduler
  import spi_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int DIV        = 4,
  parameter int FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*FRAME_BITS-1:0] tx_data,
  output logic [NREQ-1:0]            grant,
  output logic [NREQ-1:0]            done,
  output logic [FRAME_BITS-1:0]      rx_data,
  output logic                       busy,
  output logic                       cs,
  output logic                       dclk,
  output logic                       mosi,
  input  logic                       miso
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [FRAME_BITS-1:0]   rx_q, rx_d;
  logic [NREQ-1:0]         grant_q, grant_d;
  logic [NREQ-1:0]         done_q, done_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic                    mosi_q, mosi_d;
  logic                    dclk_q, dclk_d;
  logic                    cs_q, cs_d;
  logic [NREQ-1:0]         arb_grant;
  logic                    cnt_last;

  spi_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    rx_d      = rx_q;
    grant_d   = grant_q;
    done_d    = '0;
    ptr_d     = ptr_q;
    mosi_d    = mosi_q;
    dclk_d    = dclk_q;
    cs_d      = cs_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d   = ST_SETUP;
          cs_d      = 1'b0;
          grant_d   = arb_grant;
          cnt_d     = '0;
          bit_cnt_d = '0;
          for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
              shreg_d = tx_data[i*FRAME_BITS +: FRAME_BITS];
              mosi_d  = tx_data[i*FRAME_BITS + FRAME_BITS - 1];
              ptr_d   = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
          end
        end
      end

      ST_SETUP: begin
        if (cnt_last) begin
          // Leaving SETUP is the first (falling) dclk edge; MSB is already on mosi.
          state_d = ST_SHIFT;
          cnt_d   = '0;
          dclk_d  = ~CPOL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_last) begin
          cnt_d  = '0;
          dclk_d = ~dclk_q;
          if (dclk_q) begin
            // Falling edge: the previous rising edge already moved the next bit to the MSB.
            mosi_d = shreg_q[FRAME_BITS-1];
          end else begin
            shreg_d   = {shreg_q[FRAME_BITS-2:0], miso};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_last) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          cs_d    = 1'b1;
          done_d  = grant_q;
          grant_d = '0;
          rx_d    = shreg_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      // NOTE: the shift register is plain flops, not a RAM, so resetting it is cheap and keeps it X-free.
      shreg_q   <= '0;
      rx_q      <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      ptr_q     <= '0;
      mosi_q    <= 1'b0;
      dclk_q    <= CPOL;
      cs_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      rx_q      <= rx_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      ptr_q     <= ptr_d;
      mosi_q    <= mosi_d;
      dclk_q    <= dclk_d;
      cs_q      <= cs_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign rx_data = rx_q;
  assign busy    = (state_q != ST_IDLE);
  assign cs      = cs_q;
  assign dclk    = dclk_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_bus_scheduler.sv
// ---------------------------------------------------------------------------
// tb_spi_bus_scheduler
// Directed scenarios with literal expectations plus a randomized phase, all
// cross-checked every cycle against a timeline model of the frame.
// ---------------------------------------------------------------------------
module tb_spi_bus_scheduler;

  localparam int N = 2;
  localparam int D = 4;
  localparam int F = 16;
  localparam int E = 2 * F * D + D + 2;   // cycles from T to GAP entry / done

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*F-1:0] tx_data;
  logic [N-1:0]   grant, done;
  logic [F-1:0]   rx_data;
  logic           busy, cs, dclk, mosi, miso;
  logic           loop_en, miso_r;

  // Second instance at DIV=1
  logic [N-1:0]   req1;
  logic [N*F-1:0] tx1;
  logic [N-1:0]   grant1, done1;
  logic [F-1:0]   rx1;
  logic           busy1, cs1, dclk1, mosi1, miso1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : miso_r;

  spi_bus_scheduler #(.NREQ(N), .DIV(D), .FRAME_BITS(F)) u_dut (
    .clk(clk), .rst(rst), .req(req), .tx_data(tx_data), .grant(grant),
    .done(done), .rx_data(rx_data), .busy(busy), .cs(cs), .dclk(dclk),
    .mosi(mosi), .miso(miso)
  );

  spi_bus_scheduler #(.NREQ(N), .DIV(1), .FRAME_BITS(F)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .tx_data(tx1), .grant(grant1),
    .done(done1), .rx_data(rx1), .busy(busy1), .cs(cs1), .dclk(dclk1),
    .mosi(mosi1), .miso(miso1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ------------------------------------------------------------------------
  // Timeline model: a frame started at cycle t0 is fully described by
  // n = cyc - t0 (setup, 2F toggles every D cycles, hold, gap).
  // ------------------------------------------------------------------------
  initial begin
    bit           m_valid = 0;
    bit           m_active = 0;
    int           m_t0 = 0, m_owner = 0, m_ptr = 0;
    logic [F-1:0] m_tx = '0, m_shift = '0, m_rx = '0;
    logic         m_mosi = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (m_valid) begin
        logic [N-1:0] e_grant, e_done;
        logic         e_cs, e_dclk, e_busy, e_mosi;
        if (m_active) begin
          int n, t, falls, bi;
          n = cyc - m_t0;
          if (n < D + 1) t = 0;
          else begin
            t = (n - D - 1) / D + 1;
            if (t > 2 * F) t = 2 * F;
          end
          falls   = (t + 1) / 2;
          bi      = F - 1 - ((falls > 0) ? falls - 1 : 0);
          e_dclk  = (t % 2 == 0);
          e_mosi  = m_tx[bi];
          e_cs    = (n >= E);
          e_busy  = 1'b1;
          e_grant = (n < E) ? N'(1) << m_owner : '0;
          e_done  = (n == E) ? N'(1) << m_owner : '0;
        end else begin
          e_dclk = 1'b1; e_mosi = m_mosi; e_cs = 1'b1; e_busy = 1'b0;
          e_grant = '0; e_done = '0;
        end
        check("cs", cs, e_cs);
        check("dclk", dclk, e_dclk);
        check("mosi", mosi, e_mosi);
        check("busy", busy, e_busy);
        check("grant", grant, e_grant);
        check("done", done, e_done);
        check("rx_data", rx_data, m_rx);
      end
      // Advance the model using the inputs the DUT samples at the next edge.
      if (rst) begin
        m_valid = 1; m_active = 0; m_ptr = 0; m_mosi = 1'b0; m_rx = '0;
      end else if (m_valid) begin
        if (m_active) begin
          int nx, k;
          nx = cyc - m_t0 + 1;
          if (nx >= D + 1 && (nx - D - 1) % D == 0) begin
            k = (nx - D - 1) / D;
            if (k < 2 * F && k % 2 == 1) m_shift = {m_shift[F-2:0], miso};
          end
          if (nx == E) m_rx = m_shift;
          if (nx == E + D) begin
            m_active = 0;
            m_mosi   = m_tx[0];
          end
        end else if (|req) begin
          for (int i = N - 1; i >= 0; i--)
            if (req[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
          m_ptr    = (m_owner + 1) % N;
          m_tx     = tx_data[m_owner*F +: F];
          m_t0     = cyc;
          m_active = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [N-1:0] g);
    bit to = 1;
    g = '0;
    for (int b = 0; b < 400; b++) begin
      step();
      if (grant != '0) begin g = grant; to = 0; break; end
    end
    check("wait_grant_timeout", to, 0);
  endtask

  task automatic wait_done(output logic [N-1:0] d);
    bit to = 1;
    d = '0;
    for (int b = 0; b < 400; b++) begin
      step();
      if (done != '0) begin d = done; to = 0; break; end
    end
    check("wait_done_timeout", to, 0);
  endtask

  initial begin
    logic [N-1:0] g, d;
    logic [N-1:0] rr_exp [4];
    int n_hi, toggles, dones;
    logic prev;
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

    rst = 1'b1; req = '0; tx_data = '0; loop_en = 1'b1; miso_r = 1'b0;
    req1 = '0; tx1 = '0; miso1 = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_cs", cs, 1);
    check("rst_dclk", dclk, 1);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_rx", rx_data, 0);
    step();

    // Single frame, loopback; tx changed mid-frame must not matter.
    tx_data[15:0] = 16'hA5C3;
    req = 2'b01;
    for (int j = 1; j <= E; j++) begin
      step();
      if (j == 10) tx_data[15:0] = 16'h0000;
      if (j == 1) begin
        check("a_cs_fall", cs, 0);
        check("a_grant", grant, 2'b01);
        check("a_mosi_msb", mosi, 1);
      end
      if (j == D) check("a_dclk_before", dclk, 1);
      if (j == D + 1) check("a_dclk_first_fall", dclk, 0);
      if (j == E - 1) check("a_done_early", done, 0);
      if (j == E) begin
        check("a_done", done, 2'b01);
        check("a_rx", rx_data, 16'hA5C3);
        check("a_grant_clr", grant, 0);
      end
    end
    req = '0;
    repeat (10) step();

    // Reset mid-frame.
    tx_data[15:0] = 16'h1234;
    req = 2'b01;
    for (int j = 1; j <= 60; j++) step();
    rst = 1'b1;
    step();
    rst = 1'b0; req = '0;
    check("r_cs", cs, 1);
    check("r_dclk", dclk, 1);
    check("r_grant", grant, 0);
    check("r_busy", busy, 0);
    dones = 0;
    for (int j = 0; j < 150; j++) begin
      step();
      if (done != '0) dones++;
    end
    check("r_no_done", dones, 0);

    // Both requesting continuously: strict alternation.
    tx_data = {16'h5A5A, 16'h3C3C};
    req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_grant(g);
      check("rr_grant", g, rr_exp[f]);
      wait_done(d);
      check("rr_done", d, g);
      if (f < 3) begin
        n_hi = 0;
        while (cs == 1'b1 && n_hi < 50) begin
          n_hi++;
          step();
        end
        check("rr_cs_high", n_hi, D + 1);
      end
    end
    req = '0;
    repeat (2 * D + 4) step();

    // Requester 1 drops its request mid-frame.
    req = 2'b10;
    for (int j = 1; j <= 20; j++) step();
    req = 2'b00;
    wait_done(d);
    check("drop_done", d, 2'b10);
    req = 2'b01;
    wait_grant(g);
    check("drop_next_grant", g, 2'b01);
    wait_done(d);
    req = '0;
    repeat (2 * D + 4) step();

    // DIV=1 instance: all-ones out, zeros in.
    tx1[15:0] = 16'hFFFF;
    req1 = 2'b01;
    toggles = 0;
    prev = dclk1;
    for (int j = 1; j <= 36; j++) begin
      step();
      if (dclk1 != prev) toggles++;
      prev = dclk1;
      if (j == 1) check("d1_mosi", mosi1, 1);
      if (j == 34) check("d1_done_early", done1, 0);
      if (j == 35) begin
        check("d1_done", done1, 2'b01);
        check("d1_rx", rx1, 16'h0000);
        req1 = '0;
      end
    end
    check("d1_toggles", toggles, 32);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < N; i++)
        if ($urandom_range(15) == 0) req[i] = ~req[i];
      tx_data = {$urandom, $urandom};
      tx_data = tx_data[N*F-1:0];
      miso_r  = 1'($urandom_range(1));
      if (c % 1000 == 0) loop_en = ~loop_en;
      rst = ($urandom_range(799) == 0);
    end
    rst = 1'b0; req = '0;
    repeat (2 * E) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
